// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART word receive framer.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    GAP
  } state_t;

  localparam int unsigned BITS_PER_CHAR = 10;
  localparam int unsigned CNT_W         = 5;

  // Gap limit is baud_div * TIMEOUT_BITS; TIMEOUT_BITS fits in 6 bits.
  function automatic int unsigned gap_limit_w(input int unsigned div_w);
    return div_w + 6;
  endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// Saturating inter-byte gap counter; expire is a 1-cycle flag raised on the
// last idle cycle before the limit (baud_div * TIMEOUT_BITS). Zero limit disables it.
module uart_gap_timer
  import uart_rx_pkg::*;
#(
  parameter int unsigned DIV_W        = 16,
  parameter int unsigned TIMEOUT_BITS = 35
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [DIV_W-1:0] baud_div,
  output logic             expire
);

  localparam int unsigned LW = gap_limit_w(DIV_W);

  logic [LW-1:0] limit;
  logic [LW-1:0] count;

  assign limit = LW'(baud_div) * LW'(TIMEOUT_BITS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || (limit == '0)) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + LW'(1);
    end
  end

  assign expire = enable && !clear && (limit != '0) && (count == limit - LW'(1));

endmodule

// File: rtl/uart_word_rx_framer.sv
// Packs received UART bytes into words, flushing partial words and marking
// frame ends on idle gaps. Optional statistics: define UART_FRAMER_STATS_EN.
module uart_word_rx_framer
  import uart_rx_pkg::*;
#(
  parameter int unsigned BYTES_PER_WORD = 2,
  parameter int unsigned MSB_FIRST      = 1,
  parameter int unsigned TIMEOUT_BITS   = (7 * BITS_PER_CHAR) / 2,
  parameter int unsigned DIV_W          = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        byte_valid,
  input  logic [7:0]                  byte_data,
  input  logic [DIV_W-1:0]            baud_div,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [8*BYTES_PER_WORD-1:0] out_data,
  output logic [CNT_W-1:0]            out_count,
  output logic                        out_partial,
  output logic                        frame_end,
  output logic                        overflow
`ifdef UART_FRAMER_STATS_EN
  ,
  output logic [15:0]                 stat_words,
  output logic [15:0]                 stat_partials,
  output logic [15:0]                 stat_overflows
`endif
);

  localparam int unsigned     W     = 8 * BYTES_PER_WORD;
  localparam logic [CNT_W-1:0] N_CNT = CNT_W'(BYTES_PER_WORD);

  state_t           state, state_next;
  logic [CNT_W-1:0] byte_cnt, cnt_next, cnt_inc;
  logic [W-1:0]     shift, shift_next, packed_word, load_data;
  logic [CNT_W-1:0] load_count;
  logic             load, load_partial, fe_next, accept;
  logic             expire;

  uart_gap_timer #(
    .DIV_W       (DIV_W),
    .TIMEOUT_BITS(TIMEOUT_BITS)
  ) u_gap_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (byte_valid || (state == IDLE)),
    .enable  (state != IDLE),
    .baud_div(baud_div),
    .expire  (expire)
  );

  assign cnt_inc = byte_cnt + CNT_W'(1);

  always_comb begin
    if (MSB_FIRST != 0) begin
      packed_word = (shift << 8) | W'(byte_data);
    end else begin
      packed_word = shift | (W'(byte_data) << {byte_cnt, 3'b000});
    end
  end

  // IDLE and GAP always hold an empty shift register, so a byte in any state
  // follows the same path; a byte arriving with expire suppresses the timeout.
  always_comb begin
    state_next   = state;
    cnt_next     = byte_cnt;
    shift_next   = shift;
    load         = 1'b0;
    load_data    = packed_word;
    load_count   = N_CNT;
    load_partial = 1'b0;
    fe_next      = 1'b0;
    if (byte_valid) begin
      if (cnt_inc == N_CNT) begin
        load       = 1'b1;
        shift_next = '0;
        cnt_next   = '0;
        state_next = GAP;
      end else begin
        shift_next = packed_word;
        cnt_next   = cnt_inc;
        state_next = COLLECT;
      end
    end else if (expire) begin
      fe_next    = 1'b1;
      state_next = IDLE;
      shift_next = '0;
      cnt_next   = '0;
      if (state == COLLECT) begin
        load         = 1'b1;
        load_data    = shift;
        load_count   = byte_cnt;
        load_partial = 1'b1;
      end
    end
  end

  assign accept = load && (!out_valid || out_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      byte_cnt    <= '0;
      shift       <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_count   <= '0;
      out_partial <= 1'b0;
      frame_end   <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state     <= state_next;
      byte_cnt  <= cnt_next;
      shift     <= shift_next;
      frame_end <= fe_next;
      overflow  <= load && !accept;
      if (accept) begin
        out_valid   <= 1'b1;
        out_data    <= load_data;
        out_count   <= load_count;
        out_partial <= load_partial;
      end else if (!load && out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef UART_FRAMER_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_words     <= '0;
      stat_partials  <= '0;
      stat_overflows <= '0;
    end else begin
      if (accept && !load_partial && (stat_words != '1)) begin
        stat_words <= stat_words + 16'd1;
      end
      if (accept && load_partial && (stat_partials != '1)) begin
        stat_partials <= stat_partials + 16'd1;
      end
      if (load && !accept && (stat_overflows != '1)) begin
        stat_overflows <= stat_overflows + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_uart_word_rx_framer.sv
// Bench for uart_word_rx_framer: three configurations driven in parallel,
// directed scenarios plus randomized traffic against a byte-queue model.
module tb_uart_word_rx_framer;

  localparam int unsigned TO = 35;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic [15:0] baud_div = 16'd0;
  logic        out_ready = 1'b0;

  logic        dv[3];
  logic [4:0]  dc[3];
  logic        dp[3];
  logic        dfe[3];
  logic        dovf[3];
  logic [15:0] od0, od1;
  logic [31:0] od2;
  logic [127:0] dd[3];
`ifdef UART_FRAMER_STATS_EN
  logic [15:0] sw[3], sp[3], so[3];
`endif

  assign dd[0] = {112'd0, od0};
  assign dd[1] = {112'd0, od1};
  assign dd[2] = {96'd0, od2};

  int checks = 0;
  int failures = 0;

  uart_word_rx_framer #(.BYTES_PER_WORD(2), .MSB_FIRST(1), .TIMEOUT_BITS(35), .DIV_W(16)) d0 (
    .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data), .baud_div(baud_div),
    .out_valid(dv[0]), .out_ready(out_ready), .out_data(od0), .out_count(dc[0]),
    .out_partial(dp[0]), .frame_end(dfe[0]), .overflow(dovf[0])
`ifdef UART_FRAMER_STATS_EN
    , .stat_words(sw[0]), .stat_partials(sp[0]), .stat_overflows(so[0])
`endif
  );

  uart_word_rx_framer #(.BYTES_PER_WORD(2), .MSB_FIRST(0), .TIMEOUT_BITS(35), .DIV_W(16)) d1 (
    .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data), .baud_div(baud_div),
    .out_valid(dv[1]), .out_ready(out_ready), .out_data(od1), .out_count(dc[1]),
    .out_partial(dp[1]), .frame_end(dfe[1]), .overflow(dovf[1])
`ifdef UART_FRAMER_STATS_EN
    , .stat_words(sw[1]), .stat_partials(sp[1]), .stat_overflows(so[1])
`endif
  );

  uart_word_rx_framer #(.BYTES_PER_WORD(4), .MSB_FIRST(1), .TIMEOUT_BITS(35), .DIV_W(16)) d2 (
    .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data), .baud_div(baud_div),
    .out_valid(dv[2]), .out_ready(out_ready), .out_data(od2), .out_count(dc[2]),
    .out_partial(dp[2]), .frame_end(dfe[2]), .overflow(dovf[2])
`ifdef UART_FRAMER_STATS_EN
    , .stat_words(sw[2]), .stat_partials(sp[2]), .stat_overflows(so[2])
`endif
  );

  always #5 clk = ~clk;

  // Reference model: a queue of pending bytes and a count of idle cycles.
  int unsigned  m_N[3] = '{2, 2, 4};
  bit           m_msb[3] = '{1'b1, 1'b0, 1'b1};
  logic [7:0]   m_buf[3][16];
  int unsigned  m_n[3];
  int unsigned  m_idle[3];
  bit           m_active[3];
  bit           m_ov[3], m_op[3], m_fe[3], m_ovf[3];
  logic [127:0] m_od[3];
  int unsigned  m_oc[3];

  function automatic logic [127:0] word_of(input int i);
    logic [127:0] v = '0;
    for (int k = 0; k < int'(m_n[i]); k++) begin
      if (m_msb[i]) v = (v << 8) | 128'(m_buf[i][k]);
      else v = v | (128'(m_buf[i][k]) << (8 * k));
    end
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_n[i] = 0; m_idle[i] = 0; m_active[i] = 0;
      m_ov[i] = 0; m_op[i] = 0; m_fe[i] = 0; m_ovf[i] = 0;
      m_od[i] = '0; m_oc[i] = 0;
    end
  endtask

  task automatic model_step(input bit bv, input logic [7:0] bd, input bit rdy, input int unsigned div);
    int unsigned lim;
    bit ld, part;
    logic [127:0] w;
    int unsigned cnt;
    lim = div * TO;
    for (int i = 0; i < 3; i++) begin
      ld = 0; part = 0; w = '0; cnt = 0;
      m_fe[i] = 0; m_ovf[i] = 0;
      if (bv) begin
        m_buf[i][m_n[i]] = bd;
        m_n[i]++;
        m_active[i] = 1;
        m_idle[i] = 0;
        if (m_n[i] == m_N[i]) begin
          ld = 1; w = word_of(i); cnt = m_n[i]; m_n[i] = 0;
        end
      end else if (m_active[i] && lim != 0) begin
        m_idle[i]++;
        if (m_idle[i] == lim) begin
          m_fe[i] = 1;
          m_active[i] = 0;
          if (m_n[i] > 0) begin
            ld = 1; part = 1; w = word_of(i); cnt = m_n[i]; m_n[i] = 0;
          end
        end
      end
      if (ld) begin
        if (!m_ov[i] || rdy) begin
          m_ov[i] = 1; m_od[i] = w; m_oc[i] = cnt; m_op[i] = part;
        end else begin
          m_ovf[i] = 1;
        end
      end else if (m_ov[i] && rdy) begin
        m_ov[i] = 0;
      end
    end
  endtask

  task automatic cycle(input bit bv, input logic [7:0] bd);
    byte_valid = bv;
    byte_data = bd;
    @(posedge clk);
    model_step(bv, bd, out_ready, int'(baud_div));
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 8'h00);
  endtask

  task automatic test_reset();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({dv[i], dd[i], dc[i], dp[i], dfe[i], dovf[i]} !== '0) begin
        failures++;
        $display("FAIL reset_outputs inst=%0d got valid=%0b data=%0h count=%0d partial=%0b fe=%0b ovf=%0b exp all 0",
                 i, dv[i], dd[i], dc[i], dp[i], dfe[i], dovf[i]);
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_word_order();
    baud_div = 16'd4;
    out_ready = 1'b1;
    cycle(1'b1, 8'h12);
    cycle(1'b1, 8'h34);
    checks++;
    if ({dv[0], dd[0], dc[0], dp[0]} !== {1'b1, 128'h1234, 5'd2, 1'b0}) begin
      failures++;
      $display("FAIL msb_word got valid=%0b data=%0h count=%0d partial=%0b exp 1 1234 2 0", dv[0], dd[0], dc[0], dp[0]);
    end
    checks++;
    if ({dv[1], dd[1]} !== {1'b1, 128'h3412}) begin
      failures++;
      $display("FAIL lsb_word got valid=%0b data=%0h exp 1 3412", dv[1], dd[1]);
    end
    for (int k = 1; k < 140; k++) begin
      cycle(1'b0, 8'h00);
      checks++;
      if (dfe[0] !== 1'b0) begin
        failures++;
        $display("FAIL early_frame_end idle=%0d got=%0b exp=0", k, dfe[0]);
      end
    end
    cycle(1'b0, 8'h00);
    checks++;
    if ({dfe[0], dfe[1]} !== 2'b11) begin
      failures++;
      $display("FAIL frame_end_140 got=%b exp=11", {dfe[0], dfe[1]});
    end
    checks++;
    if ({dv[2], dd[2], dc[2], dp[2], dfe[2]} !== {1'b1, 128'h1234, 5'd2, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL n4_flush_1234 got valid=%0b data=%0h count=%0d partial=%0b fe=%0b exp 1 1234 2 1 1",
               dv[2], dd[2], dc[2], dp[2], dfe[2]);
    end
    cycle(1'b0, 8'h00);
    checks++;
    if ({dfe[0], dfe[1], dfe[2]} !== 3'b000) begin
      failures++;
      $display("FAIL frame_end_pulse got=%b exp=000", {dfe[0], dfe[1], dfe[2]});
    end
  endtask

  task automatic test_partial();
    cycle(1'b1, 8'hAA);
    cycle(1'b1, 8'hBB);
    idle(139);
    checks++;
    if ({dv[2], dfe[2]} !== 2'b00) begin
      failures++;
      $display("FAIL partial_early got valid=%0b fe=%0b exp 0 0", dv[2], dfe[2]);
    end
    cycle(1'b0, 8'h00);
    checks++;
    if ({dv[2], dd[2], dc[2], dp[2], dfe[2]} !== {1'b1, 128'h0000AABB, 5'd2, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL partial_flush got valid=%0b data=%0h count=%0d partial=%0b fe=%0b exp 1 aabb 2 1 1",
               dv[2], dd[2], dc[2], dp[2], dfe[2]);
    end
    idle(2);
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    cycle(1'b1, 8'h01);
    cycle(1'b1, 8'h02);
    cycle(1'b1, 8'h03);
    cycle(1'b1, 8'h04);
    checks++;
    if ({dv[0], dd[0], dovf[0]} !== {1'b1, 128'h0102, 1'b1}) begin
      failures++;
      $display("FAIL overflow_d0 got valid=%0b data=%0h ovf=%0b exp 1 0102 1", dv[0], dd[0], dovf[0]);
    end
    checks++;
    if ({dv[1], dd[1], dovf[1]} !== {1'b1, 128'h0201, 1'b1}) begin
      failures++;
      $display("FAIL overflow_d1 got valid=%0b data=%0h ovf=%0b exp 1 0201 1", dv[1], dd[1], dovf[1]);
    end
    checks++;
    if ({dv[2], dd[2], dovf[2]} !== {1'b1, 128'h01020304, 1'b0}) begin
      failures++;
      $display("FAIL no_overflow_d2 got valid=%0b data=%0h ovf=%0b exp 1 01020304 0", dv[2], dd[2], dovf[2]);
    end
    cycle(1'b0, 8'h00);
    checks++;
    if ({dv[0], dd[0], dovf[0]} !== {1'b1, 128'h0102, 1'b0}) begin
      failures++;
      $display("FAIL overflow_hold got valid=%0b data=%0h ovf=%0b exp 1 0102 0", dv[0], dd[0], dovf[0]);
    end
`ifdef UART_FRAMER_STATS_EN
    checks++;
    if ({so[0], so[1], so[2]} !== {16'd1, 16'd1, 16'd0}) begin
      failures++;
      $display("FAIL stat_overflows got=%0d,%0d,%0d exp 1,1,0", so[0], so[1], so[2]);
    end
`endif
    out_ready = 1'b1;
    cycle(1'b0, 8'h00);
    checks++;
    if ({dv[0], dv[1], dv[2]} !== 3'b000) begin
      failures++;
      $display("FAIL consume_after_ready got=%b exp=000", {dv[0], dv[1], dv[2]});
    end
    idle(150);
  endtask

  task automatic test_simultaneous();
    cycle(1'b1, 8'hC1);
    idle(139);
    cycle(1'b1, 8'hC2);
    checks++;
    if (dfe[2] !== 1'b0) begin
      failures++;
      $display("FAIL byte_wins_fe got=%0b exp=0", dfe[2]);
    end
    for (int k = 1; k < 140; k++) begin
      cycle(1'b0, 8'h00);
      checks++;
      if ({dv[2], dfe[2]} !== 2'b00) begin
        failures++;
        $display("FAIL counter_cleared idle=%0d got valid=%0b fe=%0b exp 0 0", k, dv[2], dfe[2]);
      end
    end
    cycle(1'b1, 8'hC3);
    cycle(1'b1, 8'hC4);
    checks++;
    if ({dv[2], dd[2], dc[2], dp[2]} !== {1'b1, 128'hC1C2C3C4, 5'd4, 1'b0}) begin
      failures++;
      $display("FAIL byte_in_word got valid=%0b data=%0h count=%0d partial=%0b exp 1 c1c2c3c4 4 0",
               dv[2], dd[2], dc[2], dp[2]);
    end
    idle(150);
  endtask

  task automatic test_div_zero();
    baud_div = 16'd0;
    cycle(1'b1, 8'h55);
    for (int k = 0; k < 300; k++) begin
      cycle(1'b0, 8'h00);
      checks++;
      if ({dv[0], dfe[0], dfe[2]} !== 3'b000) begin
        failures++;
        $display("FAIL div_zero idle=%0d got valid=%0b fe0=%0b fe2=%0b exp 0 0 0", k, dv[0], dfe[0], dfe[2]);
      end
    end
  endtask

  task automatic test_reset_mid_word();
    out_ready = 1'b0;
    cycle(1'b1, 8'h66);
    cycle(1'b1, 8'h77);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({dv[i], dd[i], dc[i], dp[i], dfe[i], dovf[i]} !== '0) begin
        failures++;
        $display("FAIL mid_reset inst=%0d got valid=%0b data=%0h count=%0d partial=%0b exp all 0",
                 i, dv[i], dd[i], dc[i], dp[i]);
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    baud_div = 16'd4;
    out_ready = 1'b1;
    cycle(1'b1, 8'h88);
    cycle(1'b1, 8'h99);
    checks++;
    if ({dv[0], dd[0], dc[0], dp[0]} !== {1'b1, 128'h8899, 5'd2, 1'b0}) begin
      failures++;
      $display("FAIL clean_word_after_reset got valid=%0b data=%0h count=%0d partial=%0b exp 1 8899 2 0",
               dv[0], dd[0], dc[0], dp[0]);
    end
    idle(150);
  endtask

  task automatic test_random();
    int unsigned divs[4] = '{1, 2, 0, 3};
    bit s_bv[$];
    logic [7:0] s_bd[$];
    bit s_rdy[$];
    int unsigned lim, nb, g, r;
    for (int seg = 0; seg < 4; seg++) begin
      baud_div = 16'(divs[seg]);
      apply_reset();
      lim = divs[seg] * TO;
      s_bv.delete(); s_bd.delete(); s_rdy.delete();
      while (s_bv.size() < 700) begin
        nb = $urandom_range(1, 9);
        for (int b = 0; b < int'(nb); b++) begin
          s_bv.push_back(1'b1); s_bd.push_back(8'($urandom)); s_rdy.push_back($urandom_range(0, 3) != 0);
          g = (b < int'(nb) - 1) ? $urandom_range(0, 2) : 0;
          for (int k = 0; k < int'(g); k++) begin
            s_bv.push_back(1'b0); s_bd.push_back(8'h00); s_rdy.push_back($urandom_range(0, 3) != 0);
          end
        end
        r = $urandom_range(0, 9);
        if (lim == 0) g = $urandom_range(0, 40);
        else if (r < 4) g = $urandom_range(0, 5);
        else if (r < 7) g = lim - 1;
        else if (r == 7) g = lim;
        else g = lim + $urandom_range(0, 30);
        for (int k = 0; k < int'(g); k++) begin
          s_bv.push_back(1'b0); s_bd.push_back(8'h00); s_rdy.push_back($urandom_range(0, 3) != 0);
        end
      end
      for (int n = 0; n < s_bv.size(); n++) begin
        out_ready = s_rdy[n];
        cycle(s_bv[n], s_bd[n]);
        for (int i = 0; i < 3; i++) begin
          checks++;
          if ({dv[i], dfe[i], dovf[i]} !== {m_ov[i], m_fe[i], m_ovf[i]}) begin
            failures++;
            $display("FAIL rand_flags seg=%0d cyc=%0d inst=%0d got v/fe/ovf=%0b%0b%0b exp %0b%0b%0b",
                     seg, n, i, dv[i], dfe[i], dovf[i], m_ov[i], m_fe[i], m_ovf[i]);
          end
          if (m_ov[i]) begin
            checks++;
            if ({dd[i], dc[i], dp[i]} !== {m_od[i], 5'(m_oc[i]), m_op[i]}) begin
              failures++;
              $display("FAIL rand_word seg=%0d cyc=%0d inst=%0d got data=%0h count=%0d partial=%0b exp %0h %0d %0b",
                       seg, n, i, dd[i], dc[i], dp[i], m_od[i], m_oc[i], m_op[i]);
            end
          end
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_word_order();
    test_partial();
    test_overflow();
    test_simultaneous();
    test_div_zero();
    test_reset_mid_word();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_word_rx_framer.md
Name: uart_word_rx_framer

Overview:
- Assembles a stream of received UART bytes into words of BYTES_PER_WORD bytes, in either byte order.
- Detects inter-byte gaps longer than a programmable number of bit times (Modbus-style 3.5-character idle) to flush partial words and mark frame ends.
- Sits between a single-byte UART receiver and downstream consumers, which read through a 1-deep valid/ready output register.

Parameters:
- BYTES_PER_WORD, 2, bytes per output word; legal range 1..16.
- MSB_FIRST, 1, 1: first received byte is most significant; 0: first received byte is least significant.
- TIMEOUT_BITS, 35, idle gap length in bit times (35 = 3.5 characters of 10 bits); legal range 1..63.
- DIV_W, 16, width of baud_div.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous, active-high reset.
- byte_valid, input, 1, 1-cycle strobe; byte_data is valid in the same cycle.
- byte_data, input, 8, received byte.
- baud_div, input, DIV_W, clocks per UART bit; 0 disables the timeout.
- out_valid, output, 1, output word available.
- out_ready, input, 1, consumer accepts the word when out_valid && out_ready.
- out_data, output, 8*BYTES_PER_WORD, assembled word.
- out_count, output, 5, number of valid bytes in out_data (1..BYTES_PER_WORD).
- out_partial, output, 1, word was flushed by timeout before it was full.
- frame_end, output, 1, 1-cycle pulse when the idle gap expires after at least one byte.
- overflow, output, 1, 1-cycle pulse when a word is dropped because the output register is occupied.

Behaviour:
- Reset (async): all outputs 0; state IDLE; byte count 0; gap counter 0; shift register 0.
- Gap limit is baud_div*TIMEOUT_BITS, computed at width DIV_W+6 with no truncation. baud_div is sampled continuously; software changes it only while idle.
- States:
  - IDLE: no bytes held, gap counter stopped. byte_valid -> COLLECT, or directly to GAP with a word load when BYTES_PER_WORD==1.
  - COLLECT: 1..N-1 bytes held, gap counter runs.
    - byte_valid: store the byte, clear the counter. If the count reaches N, load the output and go to GAP.
    - Counter reaches limit-1 with no byte_valid: partial flush (load with out_partial=1), assert frame_end, go to IDLE.
  - GAP: word complete, waiting for the next byte or the frame end; counter runs.
    - byte_valid: start a new word in COLLECT (or load immediately if N==1), clear the counter.
    - Timeout: frame_end pulse, go to IDLE, no load.
- Byte packing:
  - MSB_FIRST=1: shift left by 8, new byte into [7:0]. A partial word is right-aligned, upper bytes zero.
  - MSB_FIRST=0: byte k goes to [8k+7:8k]; unfilled upper bytes zero.
  - The shift register clears after each load.
- Output latency: the last byte (or timeout) in cycle t gives out_valid=1 at t+1, with out_data, out_count and out_partial stable until accepted. frame_end is asserted at t+1.
- Load vs. output register:
  - A load succeeds if !out_valid, or if out_valid && out_ready in the same cycle (back-to-back allowed).
  - Otherwise the new word is discarded, the held word is kept, and overflow pulses at t+1.
- Simultaneous events: byte_valid in the same cycle the counter would expire means the byte wins (accepted, counter cleared, no timeout).
- baud_div==0: no timeout, no frame_end, no partial flush; the counter stays at 0.
- Gap counter saturates and never wraps.

Optional Feature:
- Macro UART_FRAMER_STATS_EN.
- Defined: adds output ports stat_words, stat_partials and stat_overflows (16 bits each). They count successful full loads, successful partial loads and overflow events respectively. All saturate at 0xFFFF and reset to 0.
- Undefined: the ports and counters are absent; core behaviour is identical.

Decomposition:
- Package uart_rx_pkg holds:
  - state enum (IDLE, COLLECT, GAP);
  - the 10-bits-per-character constant;
  - the gap-limit width function (DIV_W+6);
  - the count width constant (5).
- One sub-module, uart_gap_timer: clear/enable inputs, baud_div, saturating counter, 1-cycle expire output. The framer FSM, packing and output register stay in the top module.

Test Plan:
- N=2, MSB_FIRST=1, baud_div=4: bytes 0x12, 0x34 -> out_data=0x1234, count=2, partial=0 one cycle after the 2nd byte. After 140 idle clocks, a frame_end pulse.
- N=2, MSB_FIRST=0: bytes 0x12, 0x34 -> out_data=0x3412.
- N=4, MSB_FIRST=1, baud_div=4: bytes 0xAA, 0xBB, then 140 idle clocks -> out_data=0x0000AABB, count=2, partial=1, frame_end in the same cycle as out_valid.
- out_ready held 0, two full words -> first word held, overflow pulses once, stat_overflows=1. Raise out_ready -> first word consumed.
- byte_valid driven exactly in the expire cycle -> no frame_end, counter cleared, byte included in the current word.
- baud_div=0, one byte with N=2 and a long idle -> no out_valid, no frame_end. Assert reset mid-word -> all outputs 0, next two bytes form a clean word.
